// File: rtl/norm_pkg.sv
// Shared widths, shift amounts and controller state encoding for the
// FastICA weight-normalisation sequencer.
package norm_pkg;
  localparam int W_W      = 26;
  localparam int SUM_W    = 30;
  localparam int N_ELEM   = 16;
  localparam int ITER     = 64;
  localparam int DIV_W    = 64;
  localparam int SHIFT_UP = 38;
  localparam int SHIFT_DN = 25;
  localparam int IDX_W    = $clog2(N_ELEM);
  localparam int CNT_W    = $clog2(ITER) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    CHECK,
    DLOAD,
    DITER,
    DWRITE,
    DONE
  } state_t;
endpackage

// File: rtl/norm_serial_div.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The load edge already resolves the first bit, so valid rises ITER cycles after load.
module norm_serial_div
  import norm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             valid
);
  logic [SUM_W-1:0] rem, rem_src, rem_nxt, dvsr, dvsr_src;
  logic [DIV_W-1:0] quo_src, quo_nxt;
  logic [SUM_W:0]   shifted, sub;
  logic [CNT_W-1:0] cnt;
  logic             ge;

  always_comb begin
    rem_src  = load ? '0 : rem;
    quo_src  = load ? dividend : quotient;
    dvsr_src = load ? divisor : dvsr;
    shifted  = {rem_src, quo_src[DIV_W-1]};
    ge       = (shifted >= {1'b0, dvsr_src});
    sub      = shifted - {1'b0, dvsr_src};
    // The partial remainder stays below the divisor, so SUM_W bits always hold it.
    rem_nxt  = SUM_W'(ge ? sub : shifted);
    quo_nxt  = {quo_src[DIV_W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      dvsr     <= '0;
      quotient <= '0;
      cnt      <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load) begin
        rem      <= rem_nxt;
        quotient <= quo_nxt;
        dvsr     <= divisor;
        cnt      <= CNT_W'(ITER - 1);
      end else if (cnt != '0) begin
        rem      <= rem_nxt;
        quotient <= quo_nxt;
        cnt      <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/norm_div_sched.sv
// Normalises a 4x4 weight matrix by its element sum, sharing one serial
// divider across all elements: out = ((w <<< 38) / sum) >>> 25.
module norm_div_sched
  import norm_pkg::*;
(
  input  logic                    clk_norm,
  input  logic                    rst_norm,
  input  logic                    start,
  input  logic [N_ELEM*W_W-1:0]   w_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err_div0,
  output logic [N_ELEM*W_W-1:0]   w_out
);
  // Handshake: start is sampled only while idle (busy low); a start seen while
  // busy is dropped. done pulses for one cycle with busy already low and w_out
  // holding the new result; w_out is otherwise stable between runs.
  state_t           state, state_nxt;
  logic [W_W-1:0]   w_sh   [N_ELEM];
  logic [W_W-1:0]   res_sh [N_ELEM];
  logic [SUM_W-1:0] acc, divisor;
  logic [IDX_W-1:0] elem;
  logic             neg, last_elem, div_load, div_valid;
  logic [W_W-1:0]   w_cur, w_mag, res;
  logic [DIV_W-1:0] dividend, quotient;
  logic signed [DIV_W-1:0] q_signed;

  assign w_cur     = w_sh[elem];
  assign last_elem = (elem == IDX_W'(N_ELEM - 1));
  assign w_mag     = w_cur[W_W-1] ? -w_cur : w_cur;
  assign dividend  = {w_mag, {SHIFT_UP{1'b0}}};
  assign divisor   = acc[SUM_W-1] ? -acc : acc;
  assign div_load  = (state == DLOAD);
  // Dividing magnitudes then negating truncates toward zero, like a signed divide.
  assign q_signed  = neg ? -$signed(quotient) : $signed(quotient);
  assign res       = W_W'(q_signed >>> SHIFT_DN);
  assign busy      = (state != IDLE);

  norm_serial_div u_div (
    .clk      (clk_norm),
    .rst      (rst_norm),
    .load     (div_load),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .valid    (div_valid)
  );

  always_ff @(posedge clk_norm) begin
    if (rst_norm) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SUM;
      SUM:     if (last_elem) state_nxt = CHECK;
      CHECK:   state_nxt = (acc == '0) ? DONE : DLOAD;
      DLOAD:   state_nxt = DITER;
      DITER:   if (div_valid) state_nxt = DWRITE;
      DWRITE:  state_nxt = last_elem ? DONE : DLOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_norm) begin
    if (rst_norm) begin
      for (int k = 0; k < N_ELEM; k++) begin
        w_sh[k]   <= '0;
        res_sh[k] <= '0;
      end
      acc      <= '0;
      elem     <= '0;
      neg      <= 1'b0;
      done     <= 1'b0;
      err_div0 <= 1'b0;
      w_out    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          for (int k = 0; k < N_ELEM; k++) w_sh[k] <= w_in[k*W_W +: W_W];
          acc      <= '0;
          elem     <= '0;
          err_div0 <= 1'b0;
        end
        SUM: begin
          acc  <= acc + {{(SUM_W-W_W){w_cur[W_W-1]}}, w_cur};
          elem <= elem + 1'b1;
        end
        CHECK: begin
          elem <= '0;
          if (acc == '0) begin
            err_div0 <= 1'b1;
            for (int k = 0; k < N_ELEM; k++) res_sh[k] <= '0;
          end
        end
        DLOAD:  neg <= w_cur[W_W-1] ^ acc[SUM_W-1];
        DWRITE: begin
          res_sh[elem] <= res;
          elem         <= elem + 1'b1;
        end
        DONE: begin
          for (int k = 0; k < N_ELEM; k++) w_out[k*W_W +: W_W] <= res_sh[k];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_norm_div_sched.sv
// Bench for norm_div_sched: directed and random runs checked against a
// longint reference model through an expected-result queue.
module tb_norm_div_sched;
  localparam int W_W      = 26;
  localparam int N        = 16;
  localparam int WV       = W_W * N;
  localparam int LAT_RUN  = 18 + 16 * (64 + 2);
  localparam int LAT_DIV0 = 18;

  logic          clk_norm = 1'b0;
  logic          rst_norm;
  logic          start;
  logic [WV-1:0] w_in;
  logic          busy, done, err_div0;
  logic [WV-1:0] w_out;

  norm_div_sched dut (
    .clk_norm (clk_norm),
    .rst_norm (rst_norm),
    .start    (start),
    .w_in     (w_in),
    .busy     (busy),
    .done     (done),
    .err_div0 (err_div0),
    .w_out    (w_out)
  );

  // clock / cycle index (cyc = index of the most recent rising edge)
  always #5 clk_norm = ~clk_norm;
  int cyc = 0;
  always @(posedge clk_norm) cyc <= cyc + 1;

  // scoreboard state
  int            vectors = 0;
  int            miscompares = 0;
  logic [WV-1:0] exp_q[$];
  logic          exp_err_q[$];
  int            exp_cyc_q[$];
  logic [WV-1:0] hold_w = '0;
  logic          hold_err = 1'b0;
  int            run_e0 = 0, run_end = 0, free_edge = 0;
  bit            chk_on = 1'b0;

  task automatic chk(input string name, input logic [WV-1:0] act, input logic [WV-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // reference model: plain signed 64-bit arithmetic on the whole matrix
  function automatic void model(input logic [WV-1:0] w, output logic [WV-1:0] r, output logic e);
    longint s, p, q;
    logic signed [W_W-1:0] v;
    logic [63:0] qb;
    r = '0;
    e = 1'b0;
    s = 0;
    for (int k = 0; k < N; k++) begin
      v = w[k*W_W +: W_W];
      s += longint'(v);
    end
    if (s == 0) e = 1'b1;
    else begin
      for (int k = 0; k < N; k++) begin
        v  = w[k*W_W +: W_W];
        p  = longint'(v) * 64'sd274877906944;
        q  = p / s;
        qb = q >>> 25;
        r[k*W_W +: W_W] = qb[W_W-1:0];
      end
    end
  endfunction

  function automatic logic [WV-1:0] rand_w(input int span);
    logic [WV-1:0] r;
    int v;
    for (int k = 0; k < N; k++) begin
      v = int'($urandom_range(0, 2 * span)) - span;
      r[k*W_W +: W_W] = W_W'(v);
    end
    return r;
  endfunction

  // driver tasks
  task automatic do_reset(input int n);
    @(negedge clk_norm);
    rst_norm = 1'b1;
    start    = 1'b0;
    chk_on   = 1'b1;
    exp_q.delete();
    exp_err_q.delete();
    exp_cyc_q.delete();
    hold_w    = '0;
    hold_err  = 1'b0;
    run_e0    = 0;
    run_end   = 0;
    free_edge = cyc + 1 + n;
    repeat (n) @(negedge clk_norm);
    rst_norm = 1'b0;
  endtask

  task automatic launch(input logic [WV-1:0] w);
    logic [WV-1:0] r;
    logic e;
    int e_idx, lat;
    @(negedge clk_norm);
    w_in  = w;
    start = 1'b1;
    e_idx = cyc + 1;
    if (e_idx >= free_edge) begin
      model(w, r, e);
      lat = e ? LAT_DIV0 : LAT_RUN;
      exp_q.push_back(r);
      exp_err_q.push_back(e);
      exp_cyc_q.push_back(e_idx + lat);
      run_e0    = e_idx;
      run_end   = e_idx + lat;
      free_edge = run_end + 1;
    end
  endtask

  task automatic drop();
    @(negedge clk_norm);
    start = 1'b0;
    w_in  = rand_w(1000);
  endtask

  task automatic run_wait(input logic [WV-1:0] w);
    launch(w);
    drop();
    repeat (LAT_RUN + 4) @(negedge clk_norm);
  endtask

  // monitor: sampled 1 time unit after each rising edge
  logic [WV-1:0] mon_w;
  logic          mon_e;
  logic          exp_busy;
  always @(posedge clk_norm) begin
    #1;
    if (chk_on) begin
      if (exp_cyc_q.size() > 0 && cyc == exp_cyc_q[0]) begin
        mon_w = exp_q.pop_front();
        mon_e = exp_err_q.pop_front();
        void'(exp_cyc_q.pop_front());
        chk("done_pulse", done, 1'b1);
        chk("w_out_result", w_out, mon_w);
        chk("err_div0_result", err_div0, mon_e);
        hold_w   = mon_w;
        hold_err = mon_e;
      end else begin
        chk("no_done", done, 1'b0);
        chk("w_out_hold", w_out, hold_w);
      end
      exp_busy = (cyc >= run_e0) && (cyc < run_end);
      chk("busy", busy, exp_busy);
      if (!exp_busy) chk("err_div0_idle", err_div0, hold_err);
    end
  end

  // stimulus
  logic [WV-1:0] w;
  int s15;
  logic signed [W_W-1:0] v;
  initial begin
    rst_norm = 1'b1;
    start    = 1'b0;
    w_in     = '0;
    do_reset(2);

    // all ones: sum 16, each element 512
    w = '0;
    for (int k = 0; k < N; k++) w[k*W_W +: W_W] = W_W'(1);
    run_wait(w);

    // w11 = 2, rest 1: sum 17
    w[0 +: W_W] = W_W'(2);
    run_wait(w);

    // w11 = -16, w12 = 32, rest 0
    w = '0;
    w[0 +: W_W]   = W_W'(-16);
    w[W_W +: W_W] = W_W'(32);
    run_wait(w);

    // zero sum
    w = '0;
    w[0 +: W_W]   = W_W'(5);
    w[W_W +: W_W] = W_W'(-5);
    run_wait(w);

    // second start mid-run is ignored
    launch(rand_w(16777215));
    drop();
    repeat (499) @(negedge clk_norm);
    launch(rand_w(16777215));
    drop();
    repeat (LAT_RUN) @(negedge clk_norm);

    // reset at cycle 600 of a run aborts it
    launch(rand_w(100000));
    drop();
    repeat (598) @(negedge clk_norm);
    do_reset(1);
    repeat (700) @(negedge clk_norm);

    // back-to-back: start at the done edge ignored, one cycle later accepted
    launch(rand_w(16777215));
    drop();
    repeat (1072) @(negedge clk_norm);
    launch(rand_w(5000));
    launch(rand_w(300));
    drop();
    repeat (LAT_RUN + 4) @(negedge clk_norm);

    // random runs, one forced to a zero sum
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        w = rand_w(1000);
        s15 = 0;
        for (int k = 0; k < N - 1; k++) begin
          v = w[k*W_W +: W_W];
          s15 += int'(v);
        end
        w[(N-1)*W_W +: W_W] = W_W'(-s15);
      end else if (i == 4) begin
        w = rand_w(3);
      end else begin
        w = rand_w(16777215);
      end
      run_wait(w);
    end

    repeat (5) @(negedge clk_norm);
    chk("expected_queue_drained", WV'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/norm_div_sched.md
Name: norm_div_sched

Overview:
- Sequencing controller for weight-matrix normalisation in the FastICA pipeline.
- Takes a 4x4 matrix of signed 26-bit weights, accumulates their sum serially, then time-shares one iterative divider across all 16 elements.
- Computes out = ((w <<< 38) / sum) >>> 25 per element, replacing 16 parallel 64-bit dividers with one.
- Sits between the weight-update stage and the convergence check; start/busy/done handshake.

Parameters:
- W_W, 26, weight element width (signed)
- SUM_W, 30, accumulated sum width (signed)
- N_ELEM, 16, matrix elements (4x4, row-major)
- ITER, 64, divider iterations per element (one quotient bit per cycle)

Ports:
- clk_norm  in  1  clock, rising edge
- rst_norm  in  1  synchronous active-high reset
- start  in  1  request a normalisation run; sampled only in IDLE
- w_in  in  416  packed weights; element k (k=0 is w11, k=15 is w44) at [26k+25:26k]
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at run completion
- err_div0  out  1  sticky per run: sum was zero; cleared at next accepted start
- w_out  out  416  packed normalised weights, same layout as w_in

Behaviour:
- Reset (synchronous, rst_norm high at an edge): state=IDLE; w_out=0, busy=0, done=0, err_div0=0; accumulator, counters and shadow registers cleared. Reset mid-run aborts the run with no partial w_out update.
- States: IDLE, SUM, CHECK, DLOAD, DITER, DWRITE, DONE.
- IDLE: start=1 at edge E0 captures all of w_in into shadow registers, clears err_div0 and the accumulator, and moves to SUM. w_in is don't-care after E0.
- start while busy is ignored; it is not queued.
- SUM: 16 cycles, adding the sign-extended element at index 0..15 to the 30-bit accumulator (no overflow possible). Then CHECK.
- CHECK: if sum==0, set err_div0 and go to DONE; w_out is loaded with all zeros. Otherwise go to DLOAD with elem=0.
- DLOAD (1 cycle): dividend = |w[elem]| * 2^38 (64-bit unsigned), divisor = |sum|; quotient sign = sign(w) XOR sign(sum).
- DITER (ITER cycles): restoring shift-subtract, one quotient bit per cycle, MSB first.
- DWRITE (1 cycle):
  - Apply the sign to the quotient; this gives truncation toward zero, matching signed-divide semantics.
  - Arithmetic shift right by 25, keep the low 26 bits, and store into result shadow[elem].
  - elem==15 goes to DONE; otherwise elem++ and go to DLOAD.
- DONE (1 cycle): copy result shadow to w_out atomically, pulse done=1, return to IDLE.
- busy falls in the same cycle that done is high.
- w_out never changes except in the DONE cycle or on reset. It holds its value indefinitely between runs.
- Latency with start sampled at E0:
  - Normal run: done is high in the cycle after edge E0+18+16*(ITER+2), i.e. 1074 cycles for ITER=64.
  - Div0 run: done is high after edge E0+18.
- Zero weight with nonzero sum gives output 0. Negative results keep two's-complement in the low 26 bits.

Decomposition:
- Package norm_pkg holds W_W, SUM_W, N_ELEM, SHIFT_UP=38, SHIFT_DN=25, and the state enum.
- One sub-module, norm_serial_div: unsigned restoring divider, 64-bit dividend by 30-bit divisor.
  - Interface: load, dividend, divisor in; quotient and a valid pulse out after ITER cycles.
  - Sign handling and the final shift stay in norm_div_sched.

Test Plan:
- All 16 weights = 1 → sum=16; every w_out element = 512; done exactly 1074 cycles after the start edge; err_div0=0.
- w11=2, all others=1 (sum=17) → w_out11=963, every other element=481.
- w11=-16, w12=32, rest 0 → w_out11=-8192 (0x3FFE000 in 26 bits), w_out12=16384, rest 0.
- w11=5, w12=-5, rest 0 → err_div0=1, all w_out=0, done 18 cycles after start.
- Second start pulsed mid-run (cycle 500) with different w_in → ignored; first run's results delivered at cycle 1074. rst_norm at cycle 600 of a later run → w_out=0, busy=0 the next cycle, no done.
- Back-to-back runs: start asserted in the cycle done is high → ignored; start one cycle later is accepted. w_out holds the first result until the second run's DONE cycle.
